// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MIPS pipeline decode stage.
//                Contents: opcodes, ALUOp encodings, control-field widths
//                and bit positions, and the NOP instruction.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Opcodes, taken from instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // ALUOp encodings passed to the execute stage
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address calculation
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // use the funct field

    // Control field widths
    localparam int WB_CTL_W = 2;
    localparam int M_CTL_W  = 3;
    localparam int EX_CTL_W = 4;

    // wb_ctl = {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // m_ctl = {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // ex_ctl = {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 32-entry register file. It has two asynchronous read ports
//                and one synchronous write port. Register $0 is hard-wired
//                to zero. A write in the current cycle is forwarded straight
//                to a matching read port.
//  Ports       : clk, reset (async, active-high)
//                we / waddr / wdata      write port
//                raddr1 / rdata1         read port 1 (rs)
//                raddr2 / rdata2         read port 2 (rt)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem_q [32];
    logic [WIDTH-1:0] mem_d [32];

    // Writes to $0 are dropped, so mem_q[0] stays at its reset value of zero.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != 5'd0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Write-through bypass. The write-back stage writes on the same edge that
    // the ID/EX latch samples these ports, so the new value is forwarded here.
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = mem_q[raddr1];
        end

        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule : regfile
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
//  Module      : decode
//  Description : Instruction-decode stage. It contains the IF/ID latch,
//                the control decode, operand read from the register file,
//                immediate sign extension and the ID/EX latch.
//  Ports       : clk, reset (async, active-high)
//                npcout_in, instr_in     from fetch
//                stall, flush            hazard / branch-squash controls
//                wb_reg_write, wb_write_reg, wb_write_data   write-back port
//                wb_ctl, m_ctl, ex_ctl   registered control bundles
//                npc_out, readdat1, readdat2, sign_ext,
//                instr_2016, instr_1511  registered data fields
//  Revision    : 1.0  initial release
// ============================================================================
module decode
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    npcout_in,
    input  logic [WIDTH-1:0]    instr_in,
    input  logic                stall,
    input  logic                flush,
    input  logic                wb_reg_write,
    input  logic [4:0]          wb_write_reg,
    input  logic [WIDTH-1:0]    wb_write_data,
    output logic [WB_CTL_W-1:0] wb_ctl,
    output logic [M_CTL_W-1:0]  m_ctl,
    output logic [EX_CTL_W-1:0] ex_ctl,
    output logic [WIDTH-1:0]    npc_out,
    output logic [WIDTH-1:0]    readdat1,
    output logic [WIDTH-1:0]    readdat2,
    output logic [WIDTH-1:0]    sign_ext,
    output logic [4:0]          instr_2016,
    output logic [4:0]          instr_1511
);

    // ---------------- IF/ID latch ----------------
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [WIDTH-1:0] ifid_npc_q,   ifid_npc_d;

    // A flush takes priority over a stall. A squashed slot must not survive
    // a stall that arrives on the same cycle.
    always_comb begin
        ifid_instr_d = instr_in;
        ifid_npc_d   = npcout_in;
        if (flush) begin
            ifid_instr_d = NOP_INSTR;
            ifid_npc_d   = '0;
        end else if (stall) begin
            ifid_instr_d = ifid_instr_q;
            ifid_npc_d   = ifid_npc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_npc_q   <= '0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
        end
    end

    // ---------------- Control decode ----------------
    logic [WB_CTL_W-1:0] dec_wb;
    logic [M_CTL_W-1:0]  dec_m;
    logic [EX_CTL_W-1:0] dec_ex;

    always_comb begin
        dec_wb = '0;
        dec_m  = '0;
        dec_ex = '0;
        unique case (ifid_instr_q[31:26])
            OP_RTYPE: begin
                dec_ex[EX_REGDST]                = 1'b1;
                dec_ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
                dec_wb[WB_REGWRITE]              = 1'b1;
            end
            OP_LW: begin
                dec_ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                dec_ex[EX_ALUSRC]                = 1'b1;
                dec_m[M_MEMREAD]                 = 1'b1;
                dec_wb[WB_REGWRITE]              = 1'b1;
                dec_wb[WB_MEMTOREG]              = 1'b1;
            end
            OP_SW: begin
                dec_ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                dec_ex[EX_ALUSRC]                = 1'b1;
                dec_m[M_MEMWRITE]                = 1'b1;
            end
            OP_BEQ: begin
                dec_ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                dec_m[M_BRANCH]                  = 1'b1;
            end
            default: ;  // unsupported opcodes decode as NOP
        endcase
    end

    // ---------------- Register file ----------------
    logic [WIDTH-1:0] rf_rdata1, rf_rdata2;

    regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_reg_write),
        .waddr  (wb_write_reg),
        .wdata  (wb_write_data),
        .raddr1 (ifid_instr_q[25:21]),
        .raddr2 (ifid_instr_q[20:16]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // ---------------- ID/EX latch ----------------
    logic [WB_CTL_W-1:0] wb_ctl_q, wb_ctl_d;
    logic [M_CTL_W-1:0]  m_ctl_q,  m_ctl_d;
    logic [EX_CTL_W-1:0] ex_ctl_q, ex_ctl_d;
    logic [WIDTH-1:0]    npc_q,    npc_d;
    logic [WIDTH-1:0]    rd1_q,    rd1_d;
    logic [WIDTH-1:0]    rd2_q,    rd2_d;
    logic [WIDTH-1:0]    sext_q,   sext_d;
    logic [4:0]          rt_q,     rt_d;
    logic [4:0]          rd_q,     rd_d;

    // On a stall only the control bundles are zeroed, which injects a
    // bubble. The data fields keep flowing so the held instruction is
    // re-read next cycle.
    always_comb begin
        wb_ctl_d = stall ? '0 : dec_wb;
        m_ctl_d  = stall ? '0 : dec_m;
        ex_ctl_d = stall ? '0 : dec_ex;
        npc_d    = ifid_npc_q;
        rd1_d    = rf_rdata1;
        rd2_d    = rf_rdata2;
        sext_d   = {{(WIDTH-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
        rt_d     = ifid_instr_q[20:16];
        rd_d     = ifid_instr_q[15:11];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ctl_q <= '0;
            m_ctl_q  <= '0;
            ex_ctl_q <= '0;
            npc_q    <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            sext_q   <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            wb_ctl_q <= wb_ctl_d;
            m_ctl_q  <= m_ctl_d;
            ex_ctl_q <= ex_ctl_d;
            npc_q    <= npc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            sext_q   <= sext_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
        end
    end

    assign wb_ctl     = wb_ctl_q;
    assign m_ctl      = m_ctl_q;
    assign ex_ctl     = ex_ctl_q;
    assign npc_out    = npc_q;
    assign readdat1   = rd1_q;
    assign readdat2   = rd2_q;
    assign sign_ext   = sext_q;
    assign instr_2016 = rt_q;
    assign instr_1511 = rd_q;

endmodule : decode
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode
//  Description : Self-checking bench for the decode stage. It runs directed
//                scenarios and a randomized instruction stream, and checks
//                the results against a behavioural pipeline model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npcout_in, instr_in;
    logic        stall, flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [3:0]  ex_ctl;
    logic [31:0] npc_out, readdat1, readdat2, sign_ext;
    logic [4:0]  instr_2016, instr_1511;

    int n_checks = 0;
    int n_errors = 0;

    decode #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .npcout_in     (npcout_in),
        .instr_in      (instr_in),
        .stall         (stall),
        .flush         (flush),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .wb_ctl        (wb_ctl),
        .m_ctl         (m_ctl),
        .ex_ctl        (ex_ctl),
        .npc_out       (npc_out),
        .readdat1      (readdat1),
        .readdat2      (readdat2),
        .sign_ext      (sign_ext),
        .instr_2016    (instr_2016),
        .instr_1511    (instr_1511)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_if_instr, m_if_npc;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic [31:0] e_npc, e_rd1, e_rd2, e_se;
    logic [4:0]  e_rt, e_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control bits derived from which instruction class the opcode names.
    function automatic logic [8:0] ref_ctl(input logic [5:0] op);
        bit is_r, is_lw, is_sw, is_beq;
        int aluop;
        is_r   = (op == 6'd0);
        is_lw  = (op == 6'd35);
        is_sw  = (op == 6'd43);
        is_beq = (op == 6'd4);
        aluop  = is_r ? 2 : (is_beq ? 1 : 0);
        // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp, ALUSrc}
        return {is_r | is_lw, is_lw, is_beq, is_lw, is_sw, is_r,
                aluop[1:0], is_lw | is_sw};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_reg_write && wb_write_reg == a) return wb_write_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_if_instr = 32'd0; m_if_npc = 32'd0;
        e_wb = 0; e_m = 0; e_ex = 0; e_npc = 0; e_rd1 = 0; e_rd2 = 0;
        e_se = 0; e_rt = 0; e_rd = 0;
    endtask

    // Advances the model one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [8:0] c;
        c     = stall ? 9'd0 : ref_ctl(m_if_instr[31:26]);
        e_wb  = c[8:7];
        e_m   = c[6:4];
        e_ex  = c[3:0];
        e_npc = m_if_npc;
        e_rd1 = ref_read(m_if_instr[25:21]);
        e_rd2 = ref_read(m_if_instr[20:16]);
        e_se  = 32'($signed(m_if_instr[15:0]));
        e_rt  = m_if_instr[20:16];
        e_rd  = m_if_instr[15:11];
        if (flush) begin
            m_if_instr = 32'd0; m_if_npc = 32'd0;
        end else if (!stall) begin
            m_if_instr = instr_in; m_if_npc = npcout_in;
        end
        if (wb_reg_write && wb_write_reg != 0) m_regs[wb_write_reg] = wb_write_data;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".wb_ctl"},   {30'd0, wb_ctl}, {30'd0, e_wb});
        check({tag, ".m_ctl"},    {29'd0, m_ctl},  {29'd0, e_m});
        check({tag, ".ex_ctl"},   {28'd0, ex_ctl}, {28'd0, e_ex});
        check({tag, ".npc_out"},  npc_out,  e_npc);
        check({tag, ".readdat1"}, readdat1, e_rd1);
        check({tag, ".readdat2"}, readdat2, e_rd2);
        check({tag, ".sign_ext"}, sign_ext, e_se);
        check({tag, ".rt"},       {27'd0, instr_2016}, {27'd0, e_rt});
        check({tag, ".rd"},       {27'd0, instr_1511}, {27'd0, e_rd});
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                        input logic stl, input logic fl, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd);
        instr_in = ins; npcout_in = npc; stall = stl; flush = fl;
        wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctl"}, {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'd0);
        check({tag, ".npc"}, npc_out, 32'd0);
        check({tag, ".rd1"}, readdat1, 32'd0);
        check({tag, ".rd2"}, readdat2, 32'd0);
        check({tag, ".se"},  sign_ext, 32'd0);
        check({tag, ".fields"}, {22'd0, instr_2016, instr_1511}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, ins;
        logic [5:0]  op;
        int sel;

        reset = 1'b1;
        instr_in = 0; npcout_in = 0; stall = 0; flush = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        model_reset();
        #12;
        check_all_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // lw after writing $1
        step("lw_wr",   32'h0, 32'h0, 0, 0, 1, 5'd1, 32'h10);
        step("lw_load", 32'h8C220004, 32'h7, 0, 0, 0, 5'd0, 32'h0);
        step("lw_out",  32'h0, 32'h8, 0, 0, 0, 5'd0, 32'h0);
        check("lw.wb", {30'd0, wb_ctl}, 32'b11);
        check("lw.m",  {29'd0, m_ctl},  32'b010);
        check("lw.ex", {28'd0, ex_ctl}, 32'b0001);
        check("lw.rd1", readdat1, 32'h10);
        check("lw.se",  sign_ext, 32'h4);
        check("lw.rt",  {27'd0, instr_2016}, 32'd2);

        // beq with negative offset
        step("beq_load", 32'h1022FFFF, 32'h9, 0, 0, 0, 5'd0, 32'h0);
        step("beq_out",  32'h00602020, 32'hA, 0, 0, 0, 5'd0, 32'h0);
        check("beq.se", sign_ext, 32'hFFFFFFFF);
        check("beq.m",  {29'd0, m_ctl},  32'b100);
        check("beq.ex", {28'd0, ex_ctl}, 32'b0010);
        check("beq.wb", {30'd0, wb_ctl}, 32'b00);

        // write-through: IF/ID holds 0x00602020 while $3 is written
        step("wt_out", 32'h0, 32'hB, 0, 0, 1, 5'd3, 32'hDEADBEEF);
        check("wt.rd1", readdat1, 32'hDEADBEEF);
        check("wt.rd",  {27'd0, instr_1511}, 32'd4);
        check("wt.ex",  {28'd0, ex_ctl}, 32'b1100);

        // $0 protection: IF/ID holds 0 (rs=$0)
        step("z_wr",  32'h0, 32'hC, 0, 0, 1, 5'd0, 32'h55);
        check("z.wt", readdat1, 32'h0);
        step("z_rd",  32'h0, 32'hD, 0, 0, 0, 5'd0, 32'h0);
        check("z.rd1", readdat1, 32'h0);

        // stall for two cycles, then stall+flush together
        step("st_load", 32'h8C220004, 32'h100, 0, 0, 0, 5'd0, 32'h0);
        step("st_1",    32'hAC000000, 32'h200, 1, 0, 0, 5'd0, 32'h0);
        check("st1.ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'd0);
        check("st1.npc", npc_out, 32'h100);
        step("st_2",    32'hAC000000, 32'h200, 1, 0, 0, 5'd0, 32'h0);
        check("st2.ctl", {23'd0, wb_ctl, m_ctl, ex_ctl}, 32'd0);
        check("st2.npc", npc_out, 32'h100);
        check("st2.se",  sign_ext, 32'h4);
        step("sf",      32'hAC000000, 32'h200, 1, 1, 0, 5'd0, 32'h0);
        step("sf_out",  32'h0, 32'h300, 0, 0, 0, 5'd0, 32'h0);
        check("sf.npc", npc_out, 32'h0);
        check("sf.wb",  {30'd0, wb_ctl}, 32'b10);
        check("sf.ex",  {28'd0, ex_ctl}, 32'b1100);
        check("sf.rd",  {27'd0, instr_1511}, 32'd0);

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom_range(0, 63));
            endcase
            r = $urandom();
            // Narrow register fields toward low numbers to hit bypass often.
            ins = {op, 2'b00, r[23:21], 2'b00, r[18:16], r[15:0]};
            step("rand", ins, $urandom(),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
        end

        // reset asserted mid-stream
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step("post_rst_ld", 32'h00A00000, 32'h1, 0, 0, 0, 5'd0, 32'h0);
        step("post_rst",    32'h0, 32'h2, 0, 0, 0, 5'd0, 32'h0);
        check("post_rst.rd1_r5", readdat1, 32'h0);
        check("post_rst.wb", {30'd0, wb_ctl}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_decode
`default_nettype wire

// File: doc/decode.md
# decode

Instruction-decode stage of the single-issue MIPS pipeline, sitting directly downstream of the fetch latch. It captures the fetched instruction and next-PC into an IF/ID register and decodes the opcode into control bits. It reads two operands from an internal 32×32 register file, sign-extends the immediate, and registers everything into the ID/EX latch for the execute stage. It also accepts the write-back port from the last stage and supports stall (bubble) and flush (branch squash).

## Interface
- WIDTH, 32, datapath/PC width (only 32 is supported)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- npcout_in  in  32  next PC (PC+1, word-addressed) from fetch
- instr_in  in  32  fetched instruction from fetch
- stall  in  1  hold IF/ID; inject bubble into ID/EX
- flush  in  1  squash IF/ID to zero (taken branch)
- wb_reg_write  in  1  register-file write enable from write-back
- wb_write_reg  in  5  write-back destination register
- wb_write_data  in  32  write-back data
- wb_ctl  out  2  {RegWrite, MemtoReg}
- m_ctl  out  3  {Branch, MemRead, MemWrite}
- ex_ctl  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- npc_out  out  32  latched next PC
- readdat1, readdat2  out  32 each  rs / rt operands
- sign_ext  out  32  sign-extended instr[15:0]
- instr_2016, instr_1511  out  5 each  rt / rd fields

## Operation
- IF/ID register holds the instruction and NPC (both 32 bits).
- Control decode on IF/ID opcode instr[31:26]:
  - 0x00 R-type: RegDst=1, ALUOp=10, ALUSrc=0, RegWrite=1, all others 0.
  - 0x23 lw: ALUOp=00, ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1.
  - 0x2B sw: ALUOp=00, ALUSrc=1, MemWrite=1.
  - 0x04 beq: ALUOp=01, Branch=1.
  - Any other opcode: all control bits 0 (NOP).
- Register file: 32×32. Register $0 reads 0 always, and writes to $0 are discarded. rs = instr[25:21], rt = instr[20:16].
- Write-through: if wb_reg_write is set, wb_write_reg≠0 and wb_write_reg equals the read address, the read port returns wb_write_data in the same cycle.
- sign_ext = {16{instr[15]}, instr[15:0]}.

## Timing
- Async reset: IF/ID, ID/EX and all 32 registers go to 0 immediately. All outputs read 0 while reset is high.
  - After reset, IF/ID holds instruction 0x00000000. It decodes as an R-type write to $0 and is harmless.
- IF/ID update on each rising edge, by priority:
  - flush: clear to 0 (flush wins over stall).
  - else stall: hold the current value.
  - else: load instr_in / npcout_in.
- ID/EX loads every edge.
  - When stall=1, wb_ctl, m_ctl and ex_ctl load 0 (bubble). Data fields still load.
  - flush does not affect ID/EX directly.
- Register-file write happens on the rising edge when wb_reg_write=1.
- Latency: instr_in presented before edge N appears decoded on the outputs after edge N+1, i.e. 2 edges.
- Reset asserted mid-stream discards all in-flight instructions. The first instruction after deassert needs 2 edges.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - ALUOp encodings
  - control field widths and bit positions for wb_ctl, m_ctl, ex_ctl
  - NOP_INSTR = 32'h0
- Sub-module regfile: 2 async read ports, 1 sync write port, write-through bypass, async reset.
- Control decode is a combinational block inside decode.

## Test plan
- Reset: assert reset mid-stream → all outputs 0 immediately; readdat1 for $5 is 0 after deassert.
- lw: write $1=0x10 via write-back, then feed 0x8C220004 → after 2 edges wb_ctl=11, m_ctl=010, ex_ctl=0001, readdat1=0x10, sign_ext=0x4, instr_2016=2.
- beq negative offset: feed 0x1022FFFF → sign_ext=0xFFFFFFFF, m_ctl=100, ex_ctl=0010, wb_ctl=00.
- Write-through: IF/ID holds 0x00602020 while write-back writes $3=0xDEADBEEF in the same cycle → readdat1=0xDEADBEEF, instr_1511=4, ex_ctl=1100.
- $0 protection: write-back $0=0x55, then read $0 → readdat1=0.
- Stall/flush:
  - stall for 2 cycles → IF/ID is unchanged and ID/EX controls are 0 while data fields repeat.
  - stall and flush together → next outputs decode as a write to $0 with npc_out=0.
